// File: rtl/button_poll_master.sv
`default_nettype none
// ============================================================================
// Module      : button_poll_master
// Description : Avalon-MM read initiator that periodically polls a button PIO
//               data register. It debounces the sampled bits and presents a
//               clean level state plus one-cycle press/release pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module button_poll_master #(
  parameter int WIDTH            = 2,
  parameter int POLL_CYCLES      = 50000,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int TIMEOUT_CYCLES   = 255,
  parameter bit ACTIVE_LOW       = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [1:0]       avm_address,
  output logic             avm_read,
  input  logic             avm_waitrequest,
  input  logic [31:0]      avm_readdata,
  input  logic             avm_readdatavalid,
  output logic [WIDTH-1:0] btn_state,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release,
  output logic             timeout_err
);

  localparam int TMR_W = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [TMR_W-1:0] c_poll_last = TMR_W'(POLL_CYCLES - 1);
  localparam logic [TO_W-1:0]  c_to_last   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       c_deb       = 4'(DEBOUNCE_SAMPLES);
  localparam logic [WIDTH-1:0] c_invert    = {WIDTH{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT   = 2'd2,
    ST_UPDATE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             w_capture;
  logic             w_timeout_hit;
  logic [TMR_W-1:0] r_poll_tmr;
  logic [TO_W-1:0]  r_to_cnt;
  logic [WIDTH-1:0] r_cap;
  logic [WIDTH-1:0] w_sample;
  logic [3:0]       r_cnt     [WIDTH];
  logic [3:0]       w_cnt_inc [WIDTH];

  // The register only ever addresses word 0 of the PIO.
  assign avm_address = 2'b00;

  // Upper readdata bits carry nothing for a narrow PIO.
  generate
    if (WIDTH < 32) begin : g_unused_hi
      logic unused_readdata_hi;
      assign unused_readdata_hi = ^avm_readdata[31:WIDTH];
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // FSM next-state and bus command decode; a single read is in flight at most.
  always_comb begin
    w_next_state  = r_state;
    avm_read      = 1'b0;
    w_capture     = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable && (r_poll_tmr == c_poll_last)) w_next_state = ST_REQ;
      end
      ST_REQ: begin
        avm_read = 1'b1;
        if (!avm_waitrequest) begin
          // A zero-latency slave may return data in the accept cycle.
          if (avm_readdatavalid) begin
            w_capture    = 1'b1;
            w_next_state = ST_UPDATE;
          end else begin
            w_next_state = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (avm_readdatavalid) begin
          w_capture    = 1'b1;
          w_next_state = ST_UPDATE;
        end else if (r_to_cnt == c_to_last) begin
          w_timeout_hit = 1'b1;
          w_next_state  = ST_IDLE;
        end
      end
      ST_UPDATE: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Poll timer runs only in IDLE while enabled, so the period includes the transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_poll_tmr <= '0;
    end else if ((r_state == ST_IDLE) && enable) begin
      if (r_poll_tmr == c_poll_last) r_poll_tmr <= '0;
      else                           r_poll_tmr <= r_poll_tmr + 1'b1;
    end
  end

  // Timeout counter counts WAIT cycles and clears whenever WAIT is left.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if ((r_state == ST_WAIT) && (w_next_state == ST_WAIT)) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end else begin
      r_to_cnt <= '0;
    end
  end

  // Capture returned button bits and latch the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cap       <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (w_capture)     r_cap       <= avm_readdata[WIDTH-1:0];
      if (w_timeout_hit) timeout_err <= 1'b1;
    end
  end

  // Normalise polarity so that 1 means pressed, and pre-compute counter increments.
  always_comb begin
    w_sample = r_cap ^ c_invert;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_inc[i] = r_cnt[i] + 4'd1;
    end
  end

  // Per-bit debounce: a bit flips after DEBOUNCE_SAMPLES consecutive differing polls.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_state   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= 4'd0;
    end else begin
      btn_press   <= '0;
      btn_release <= '0;
      if (r_state == ST_UPDATE) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (w_sample[i] == btn_state[i]) begin
            r_cnt[i] <= 4'd0;
          end else if (w_cnt_inc[i] == c_deb) begin
            btn_state[i]   <= ~btn_state[i];
            btn_press[i]   <= ~btn_state[i];
            btn_release[i] <= btn_state[i];
            r_cnt[i]       <= 4'd0;
          end else begin
            r_cnt[i] <= w_cnt_inc[i];
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_button_poll_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_poll_master
// Description : Directed self-checking bench for button_poll_master with a
//               1-cycle-latency slave and a scoreboard of expected debounce
//               results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_poll_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic [1:0]  btn_state;
  logic [1:0]  btn_press;
  logic [1:0]  btn_release;
  logic        timeout_err;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int c0    = 0;
  int last_read = 0;

  typedef struct packed {
    logic [1:0] st;
    logic [1:0] pr;
    logic [1:0] rl;
  } exp_t;

  exp_t       sb_q[$];
  logic [1:0] m_st;
  int         m_cnt[2];

  button_poll_master #(
    .WIDTH(2),
    .POLL_CYCLES(8),
    .DEBOUNCE_SAMPLES(3),
    .TIMEOUT_CYCLES(16),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .btn_state(btn_state),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .timeout_err(timeout_err)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_st     = 2'b00;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    sb_q.delete();
  endtask

  // Reference debounce: active-low keys, 3 consecutive differing samples flip a bit.
  task automatic model_push(input logic [1:0] d);
    exp_t       e;
    logic [1:0] s;
    s    = ~d;
    e.pr = 2'b00;
    e.rl = 2'b00;
    for (int b = 0; b < 2; b++) begin
      if (s[b] == m_st[b]) begin
        m_cnt[b] = 0;
      end else begin
        m_cnt[b] = m_cnt[b] + 1;
        if (m_cnt[b] == 3) begin
          m_st[b]  = ~m_st[b];
          e.pr[b]  = m_st[b];
          e.rl[b]  = ~m_st[b];
          m_cnt[b] = 0;
        end
      end
    end
    e.st = m_st;
    sb_q.push_back(e);
  endtask

  // Bounded wait for the next read request; returns its cycle.
  task automatic wait_read(output int t);
    int n;
    n = 0;
    while (avm_read !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    chk("read_seen", {31'd0, avm_read}, 32'd1);
    t = cyc;
  endtask

  // One poll: optional stall, then data (or silence for a timeout).
  // gap > 0 checks distance from previous read, gap < 0 checks latency from reset release.
  task automatic do_poll(input logic [31:0] data, input int stall, input bit give, input int gap);
    int   t;
    exp_t e;
    wait_read(t);
    if (gap > 0)      chk("poll_period", 32'(t - last_read), 32'(gap));
    else if (gap < 0) chk("first_read_latency", 32'(t - c0), 32'd8);
    last_read = t;
    chk("address", {30'd0, avm_address}, 32'd0);
    avm_waitrequest = (stall > 0);
    for (int k = 0; k < stall; k++) begin
      chk("stall_read_hold", {31'd0, avm_read}, 32'd1);
      chk("stall_addr_hold", {30'd0, avm_address}, 32'd0);
      step();
    end
    avm_waitrequest = 1'b0;
    chk("req_read", {31'd0, avm_read}, 32'd1);
    step();
    chk("read_drop", {31'd0, avm_read}, 32'd0);
    if (give) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = data;
      model_push(data[1:0]);
      step();
      avm_readdatavalid = 1'b0;
      avm_readdata      = 32'hDEAD_BEE0;
      step();
      e = sb_q.pop_front();
      chk("btn_state", {30'd0, btn_state}, {30'd0, e.st});
      chk("btn_press", {30'd0, btn_press}, {30'd0, e.pr});
      chk("btn_release", {30'd0, btn_release}, {30'd0, e.rl});
      step();
      chk("pulse_clear", {28'd0, btn_press, btn_release}, 32'd0);
    end else begin
      repeat (15) step();
      chk("timeout_not_early", {31'd0, timeout_err}, 32'd0);
      step();
      chk("timeout_set", {31'd0, timeout_err}, 32'd1);
      chk("timeout_read_low", {31'd0, avm_read}, 32'd0);
    end
  endtask

  initial begin
    logic seen;
    int   t;
    reset             = 1'b1;
    enable            = 1'b1;
    avm_waitrequest   = 1'b0;
    avm_readdata      = 32'h3;
    avm_readdatavalid = 1'b0;
    model_reset();
    repeat (3) step();
    chk("rst_read", {31'd0, avm_read}, 32'd0);
    chk("rst_addr", {30'd0, avm_address}, 32'd0);
    chk("rst_state", {30'd0, btn_state}, 32'd0);
    chk("rst_pulses", {28'd0, btn_press, btn_release}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
    reset = 1'b0;
    c0    = cyc;

    // Idle keys: no change, regular period.
    do_poll(32'h3, 0, 1'b1, -1);
    do_poll(32'h3, 0, 1'b1, 11);
    do_poll(32'h3, 0, 1'b1, 11);

    // Key0 pressed for three polls, then released for three polls.
    repeat (3) do_poll(32'h2, 0, 1'b1, 11);
    repeat (3) do_poll(32'h3, 0, 1'b1, 11);

    // Bounce never reaches three in a row.
    do_poll(32'h2, 0, 1'b1, 11);
    do_poll(32'h3, 0, 1'b1, 11);
    do_poll(32'h2, 0, 1'b1, 11);
    do_poll(32'h2, 0, 1'b1, 11);
    do_poll(32'h3, 0, 1'b1, 11);

    // Five stall cycles; data still counts towards the press.
    do_poll(32'h2, 5, 1'b1, 11);
    do_poll(32'h2, 0, 1'b1, 16);
    do_poll(32'h2, 0, 1'b1, 11);

    // Silent slave, then normal debounce resumes with simultaneous flips.
    do_poll(32'h0, 0, 1'b0, 11);
    do_poll(32'h1, 0, 1'b1, 25);
    do_poll(32'h1, 0, 1'b1, 11);
    do_poll(32'h1, 0, 1'b1, 11);
    repeat (3) do_poll(32'h0, 0, 1'b1, 11);

    // Disabled polling issues no reads.
    enable = 1'b0;
    seen   = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      seen = seen | avm_read;
    end
    chk("disabled_no_read", {31'd0, seen}, 32'd0);
    enable = 1'b1;

    // Reset while waiting for data with both keys held.
    chk("pre_reset_state", {30'd0, btn_state}, 32'd3);
    wait_read(t);
    avm_waitrequest = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    chk("wait_rst_state", {30'd0, btn_state}, 32'd0);
    chk("wait_rst_read", {31'd0, avm_read}, 32'd0);
    chk("wait_rst_timeout", {31'd0, timeout_err}, 32'd0);
    reset = 1'b0;
    c0    = cyc;
    model_reset();
    avm_readdatavalid = 1'b1;
    avm_readdata      = 32'h0;
    step();
    avm_readdatavalid = 1'b0;
    step();
    chk("stale_no_update", {26'd0, btn_state, btn_press, btn_release}, 32'd0);
    do_poll(32'h0, 0, 1'b1, -1);
    do_poll(32'h0, 0, 1'b1, 11);
    do_poll(32'h0, 0, 1'b1, 11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
